// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, line levels and parity selectors.
// The RX start/parity/stop checkers import the same package.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  // A one-bit payload still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter for the UART transmitter.
// ser_bit is the next payload bit to drive; ser_done flags the last payload bit on the line.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift_en,
  input  logic                  cnt_en,
  output logic                  ser_bit,
  output logic                  ser_done
);

  localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = load_data;
    end else if (shift_en) begin
      data_d = data_q >> 1;
    end
    // The counter tracks the payload bit currently on the line and clears on leaving DATA.
    if (load) begin
      cnt_d = '0;
    end else if (cnt_en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ser_bit  = data_q[0];
  assign ser_done = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first payload, optional parity, stop bit.
// One bit per CLK; TX_OUT and Busy are registered from the next-state decode.
//
//   state     | meaning
//   ST_IDLE   | line idle high, waiting for Data_Valid
//   ST_START  | start bit on the line
//   ST_DATA   | payload bit cnt on the line
//   ST_PARITY | latched parity bit on the line
//   ST_STOP   | stop bit on the line; may accept the next word
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_e state_q, state_d;
  logic      tx_q, tx_d;
  logic      busy_q, busy_d;
  logic      par_q, par_d;
  logic      par_en_q, par_en_d;
  logic      accept;
  logic      load, shift_en, cnt_en;
  logic      ser_bit, ser_done;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk       (CLK),
    .rst       (RST),
    .load      (load),
    .load_data (P_DATA),
    .shift_en  (shift_en),
    .cnt_en    (cnt_en),
    .ser_bit   (ser_bit),
    .ser_done  (ser_done)
  );

  always_comb begin
    state_d  = state_q;
    tx_d     = IDLE_LVL;
    busy_d   = 1'b1;
    par_d    = par_q;
    par_en_d = par_en_q;
    load     = 1'b0;
    shift_en = 1'b0;
    cnt_en   = 1'b0;
    accept   = Data_Valid && ((state_q == ST_IDLE) || (state_q == ST_STOP));

    if (accept) begin
      load     = 1'b1;
      par_d    = (^P_DATA) ^ (PAR_TYP == PAR_ODD);
      par_en_d = PAR_EN;
    end

    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_START;
      ST_START: begin
        state_d  = ST_DATA;
        shift_en = 1'b1;
      end
      ST_DATA: begin
        shift_en = 1'b1;
        cnt_en   = 1'b1;
        if (ser_done) state_d = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: state_d = ST_STOP;
      ST_STOP:   state_d = accept ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Output level is chosen for the state being entered so the line changes on the same edge.
    case (state_d)
      ST_START:  tx_d = START_BIT;
      ST_DATA:   tx_d = ser_bit;
      ST_PARITY: tx_d = par_q;
      ST_STOP:   tx_d = STOP_BIT;
      default: begin
        tx_d   = IDLE_LVL;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      tx_q     <= IDLE_LVL;
      busy_q   <= 1'b0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule
